// File: rtl/tdp_ram36k_stream_reader.sv
// rtl/tdp_ram36k_stream_reader.sv - credit-based read initiator for one 36-bit TDP RAM port
//
// Reads LEN consecutive words starting at START_ADDR from a RAM port with a
// one-cycle registered read latency. The words come out as a valid/ready stream.
// Requests are issued only when the output buffer has room for the returning word.
//
// Ports:
//   CLK, RST              clock (also the RAM port clock), synchronous active-high reset
//   START, START_ADDR, LEN transfer request (sampled in IDLE only)
//   ABORT                 stop the transfer and flush the buffer
//   BUSY, DONE            status: not idle / one-cycle end-of-transfer pulse
//   REN, ADDR             RAM read request; word address on ADDR[14:5]
//   RDATA, RPARITY        RAM read return, one cycle after the RAM samples REN
//   M_VALID, M_READY      output stream handshake
//   M_DATA, M_PARITY      output stream payload
//   M_LAST                marks the final word of the transfer
module tdp_ram36k_stream_reader #(
  parameter int DEPTH     = 4,
  parameter int LEN_WIDTH = 11
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [9:0]           START_ADDR,
  input  logic [LEN_WIDTH-1:0] LEN,
  input  logic                 ABORT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 REN,
  output logic [14:0]          ADDR,
  input  logic [31:0]          RDATA,
  input  logic [3:0]           RPARITY,
  output logic                 M_VALID,
  input  logic                 M_READY,
  output logic [31:0]          M_DATA,
  output logic [3:0]           M_PARITY,
  output logic                 M_LAST
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW:0]   CREDITS  = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state, state_next;
  logic [9:0]           ptr;
  logic [9:0]           addr_q;
  logic [LEN_WIDTH-1:0] issue_left;
  logic [LEN_WIDTH-1:0] out_left;
  logic [CW-1:0]        count;
  logic [CW-1:0]        inflight;
  logic [AW-1:0]        wr_idx;
  logic [AW-1:0]        rd_idx;
  logic [35:0]          mem [DEPTH];
  logic [35:0]          head;
  logic                 ren_d;

  logic flush, issue, push, pop, last_pop, done_next;

  assign ADDR     = {addr_q, 5'b0};
  assign BUSY     = (state != IDLE);
  assign M_VALID  = (count != '0);
  assign head     = mem[rd_idx];
  // Payload is forced to zero while empty so stale buffer contents never show.
  assign M_DATA   = M_VALID ? head[31:0]  : 32'h0;
  assign M_PARITY = M_VALID ? head[35:32] : 4'h0;
  assign M_LAST   = M_VALID && (out_left == LEN_WIDTH'(1));

  always_comb begin
    state_next = state;
    flush      = ABORT && (state != IDLE);
    push       = ren_d && !flush;
    pop        = M_VALID && M_READY && !flush;
    last_pop   = pop && M_LAST;
    // Credit: every issued word already owns a buffer slot, so a word is only
    // requested when buffered plus in-flight words leave room for it.
    issue      = (state == RUN) && !flush && (issue_left != '0) &&
                 (({1'b0, count} + {1'b0, inflight}) < CREDITS);
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (START && (LEN != '0)) state_next = RUN;
        done_next = START && (LEN == '0);
      end
      RUN: begin
        if (flush)                                             state_next = IDLE;
        else if (issue && (issue_left == LEN_WIDTH'(1)))       state_next = DRAIN;
      end
      DRAIN: begin
        if (flush)         state_next = IDLE;
        else if (last_pop) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      REN        <= 1'b0;
      addr_q     <= '0;
      ren_d      <= 1'b0;
      ptr        <= '0;
      issue_left <= '0;
      out_left   <= '0;
      count      <= '0;
      inflight   <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      DONE       <= 1'b0;
    end else begin
      DONE  <= done_next;
      // A request still in the RAM pipeline at abort time is dropped here.
      ren_d <= REN && !flush;
      if (flush) begin
        REN        <= 1'b0;
        issue_left <= '0;
        out_left   <= '0;
        count      <= '0;
        inflight   <= '0;
        wr_idx     <= '0;
        rd_idx     <= '0;
      end else begin
        if ((state == IDLE) && START && (LEN != '0)) begin
          ptr        <= START_ADDR;
          issue_left <= LEN;
          out_left   <= LEN;
        end
        REN <= issue;
        if (issue) begin
          addr_q     <= ptr;
          ptr        <= ptr + 10'd1;
          issue_left <= issue_left - LEN_WIDTH'(1);
        end
        inflight <= inflight + CW'(issue) - CW'(push);
        count    <= count + CW'(push) - CW'(pop);
        if (push) wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + AW'(1);
        if (pop) begin
          rd_idx   <= (rd_idx == LAST_IDX) ? '0 : rd_idx + AW'(1);
          out_left <= out_left - LEN_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RST) mem[wr_idx] <= {RPARITY, RDATA};
  end

endmodule

// File: tb/tb_tdp_ram36k_stream_reader.sv
// tb/tb_tdp_ram36k_stream_reader.sv - self-checking bench for tdp_ram36k_stream_reader
module tb_tdp_ram36k_stream_reader;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [9:0]  START_ADDR = '0;
  logic [10:0] LEN = '0;
  logic        ABORT = 1'b0;
  logic        BUSY, DONE, REN;
  logic [14:0] ADDR;
  logic [31:0] RDATA = '0;
  logic [3:0]  RPARITY = '0;
  logic        M_VALID;
  logic        M_READY = 1'b0;
  logic [31:0] M_DATA;
  logic [3:0]  M_PARITY;
  logic        M_LAST;

  tdp_ram36k_stream_reader #(.DEPTH(DEPTH), .LEN_WIDTH(11)) dut (
    .CLK(CLK), .RST(RST), .START(START), .START_ADDR(START_ADDR), .LEN(LEN),
    .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE), .REN(REN), .ADDR(ADDR),
    .RDATA(RDATA), .RPARITY(RPARITY), .M_VALID(M_VALID), .M_READY(M_READY),
    .M_DATA(M_DATA), .M_PARITY(M_PARITY), .M_LAST(M_LAST)
  );

  always #5 CLK = ~CLK;

  // RAM port model: one-cycle registered read.
  logic [35:0] ram [1024];
  always @(posedge CLK) begin
    if (REN) {RPARITY, RDATA} <= ram[ADDR[14:5]];
  end

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];
  logic [9:0]  exp_addr_q[$];
  int issued = 0, popped = 0, done_cnt = 0, done_base = 0;
  int ready_mode = 0;
  logic        prev_stall = 1'b0;
  logic [35:0] held = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ready pattern generator: 0 always, 1 toggle, 2 random, 3 stalled.
  initial forever begin
    @(posedge CLK); #1;
    case (ready_mode)
      0: M_READY = 1'b1;
      1: M_READY = ~M_READY;
      2: M_READY = 1'($urandom_range(0, 1));
      default: M_READY = 1'b0;
    endcase
  end

  // Stream / request monitor against the expected word and address queues.
  always @(negedge CLK) begin
    logic [35:0] w;
    logic [9:0]  a;
    if (!RST) begin
      if (REN) begin
        check("ren_expected", 64'(exp_addr_q.size() != 0), 64'(1));
        if (exp_addr_q.size() != 0) begin
          a = exp_addr_q.pop_front();
          check("addr", 64'(ADDR), 64'({a, 5'b0}));
        end
        issued++;
      end
      check("credit", 64'((issued - popped) <= DEPTH), 64'(1));
      if (prev_stall) check("hold", 64'({M_VALID, M_PARITY, M_DATA}), 64'({1'b1, held}));
      if (M_VALID && M_READY) begin
        check("word_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          check("last", 64'(M_LAST), 64'(exp_q.size() == 1));
          w = exp_q.pop_front();
          check("data", 64'({M_PARITY, M_DATA}), 64'(w));
        end
        popped++;
      end
      prev_stall = M_VALID && !M_READY && !ABORT;
      held = {M_PARITY, M_DATA};
      if (DONE) done_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_xfer(input logic [9:0] a, input int len);
    int idx;
    for (int i = 0; i < len; i++) begin
      idx = (int'(a) + i) % 1024;
      exp_q.push_back(ram[idx]);
      exp_addr_q.push_back(10'(idx));
    end
    done_base  = done_cnt;
    START_ADDR = a;
    LEN        = 11'(len);
    START      = 1'b1;
    @(posedge CLK); #1;
    START      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge CLK);
      n++;
    end
    @(negedge CLK);
    check("done_seen", 64'(done_cnt), 64'(done_base + 1));
    check("all_words_out", 64'(exp_q.size()), 64'(0));
    check("idle_after_done", 64'(BUSY), 64'(0));
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_addr_q.delete();
    popped = issued;
  endtask

  initial begin
    int n, pb, ib, db, len;
    logic [9:0] a;

    for (int i = 0; i < 1024; i++) ram[i] = {4'(i), 32'(i) * 32'h01010101};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ren", 64'(REN), 64'(0));
    check("rst_addr", 64'(ADDR), 64'(0));
    check("rst_valid_data", 64'({M_VALID, M_PARITY, M_DATA, M_LAST}), 64'(0));
    check("rst_busy_done", 64'({BUSY, DONE}), 64'(0));
    RST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      check("quiet", 64'({REN, BUSY, M_VALID, DONE, M_LAST}), 64'(0));
    end

    // Cycle-exact latency: START_ADDR=0x010, LEN=4, ready held high.
    ready_mode = 0;
    @(posedge CLK); #1;
    start_xfer(10'h010, 4);
    check("t0_ren", 64'(REN), 64'(0));
    check("t0_busy", 64'(BUSY), 64'(1));
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK); #1;
      check("lat_ren", 64'(REN), 64'(k >= 1 && k <= 4));
      if (k <= 4) check("lat_addr", 64'(ADDR[14:5]), 64'(10'h010 + 10'(k - 1)));
      check("lat_valid", 64'(M_VALID), 64'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) begin
        check("lat_data", 64'(M_DATA), 64'(32'h10101010 + 32'(k - 3) * 32'h01010101));
        check("lat_parity", 64'(M_PARITY), 64'((k - 3) & 4'hF));
        check("lat_last", 64'(M_LAST), 64'(k == 6));
      end
      check("lat_done", 64'(DONE), 64'(k == 7));
    end
    check("lat_all_out", 64'(exp_q.size()), 64'(0));

    // Address wrap 0x3FE -> 0x001
    ib = issued;
    start_xfer(10'h3FE, 4);
    wait_done(60);
    check("wrap_issued", 64'(issued - ib), 64'(4));

    // Random RAM contents from here on.
    for (int i = 0; i < 1024; i++) ram[i] = {4'($urandom), 32'($urandom)};

    // LEN=32 with toggling ready and a 10-cycle stall.
    ready_mode = 1;
    start_xfer(10'($urandom), 32);
    repeat (12) @(posedge CLK);
    #1; ready_mode = 3;
    repeat (10) @(posedge CLK);
    #1;
    check("stall_no_ren", 64'(REN), 64'(0));
    check("stall_valid", 64'(M_VALID), 64'(1));
    ready_mode = 1;
    wait_done(400);

    // LEN=0: DONE next cycle, no request.
    ready_mode = 0;
    ib = issued;
    start_xfer(10'h123, 0);
    check("len0_done", 64'(DONE), 64'(1));
    check("len0_busy", 64'({BUSY, REN}), 64'(0));
    @(posedge CLK); #1;
    check("len0_done_pulse", 64'(DONE), 64'(0));
    repeat (5) @(posedge CLK);
    #1;
    check("len0_no_ren", 64'(issued - ib), 64'(0));

    // START while busy is ignored.
    pb = popped;
    start_xfer(10'($urandom), 8);
    repeat (2) @(posedge CLK);
    #1;
    START_ADDR = 10'($urandom); LEN = 11'd2; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(100);
    repeat (10) @(posedge CLK);
    #1;
    check("restart_ignored_words", 64'(popped - pb), 64'(8));

    // Random transfers with random ready.
    ready_mode = 2;
    for (int r = 0; r < 4; r++) begin
      a   = 10'($urandom_range(0, 1023));
      len = $urandom_range(1, 40);
      start_xfer(a, len);
      wait_done(len * 8 + 50);
    end

    // ABORT after 3 pops.
    ready_mode = 0;
    @(posedge CLK); #1;
    pb = popped;
    db = done_cnt;
    start_xfer(10'($urandom), 10);
    n = 0;
    while (popped < pb + 3 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    check("abort_reached_3", 64'(popped >= pb + 3), 64'(1));
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    clear_model();
    check("abort_valid", 64'(M_VALID), 64'(0));
    check("abort_busy_ren", 64'({BUSY, REN, DONE}), 64'(0));
    repeat (6) @(posedge CLK);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(db));
    check("abort_quiet", 64'({M_VALID, BUSY}), 64'(0));
    start_xfer(10'($urandom), 5);
    wait_done(80);

    // Reset mid-transfer.
    @(posedge CLK); #1;
    db = done_cnt;
    start_xfer(10'($urandom), 20);
    repeat (6) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    clear_model();
    check("rst_mid_outputs", 64'({M_VALID, BUSY, REN, DONE, M_LAST}), 64'(0));
    check("rst_mid_addr", 64'(ADDR), 64'(0));
    RST = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check("rst_mid_no_done", 64'(done_cnt), 64'(db));
    check("rst_mid_quiet", 64'({M_VALID, BUSY}), 64'(0));
    ready_mode = 2;
    start_xfer(10'($urandom), 12);
    wait_done(200);

    repeat (5) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
